imem_boot_ctrl: RTL and testbench

Controller that owns the instruction memory write/read address path. After reset it holds the CPU stalled and accepts a program as a little-endian byte stream. It assembles the bytes into 32-bit words, writes them to instruction memory sequentially from word 0, then pulses a PC reset and releases the CPU. In run mode it maps the CPU fetch PC onto the memory word address and flags bad fetches.

---
 rtl/imem_boot_ctrl_if.sv | 35 +++
 rtl/imem_boot_ctrl.sv | 161 ++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_ctrl_if.sv
// Bus bundle for the instruction-memory boot controller: program-load byte
// stream, CPU fetch/stall control and the instruction-memory write/address path.
interface imem_boot_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic              load_start;
    logic [LEN_W-1:0]  load_len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [ADDR_W-1:0] cpu_pc;
    logic              cpu_stall;
    logic              cpu_pc_reset;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              load_done;
    logic              load_error;
    logic              fetch_fault;

    // Host / CPU side: drives load requests, program bytes and the fetch PC.
    modport master (
        output load_start, load_len, byte_valid, byte_data, cpu_pc,
        input  byte_ready, cpu_stall, cpu_pc_reset, mem_we, mem_addr,
               mem_wdata, load_done, load_error, fetch_fault
    );

    // Controller side.
    modport slave (
        input  load_start, load_len, byte_valid, byte_data, cpu_pc,
        output byte_ready, cpu_stall, cpu_pc_reset, mem_we, mem_addr,
               mem_wdata, load_done, load_error, fetch_fault
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller. Holds the CPU stalled while a program
// arrives as a little-endian byte stream, packs it into 32-bit words written
// from word 0 upward, pulses a PC reset, then hands the fetch path to the CPU.
module imem_boot_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    imem_boot_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    localparam logic [LEN_W:0]    DEPTH_L = (LEN_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [LEN_W-1:0]  ONE_L   = LEN_W'(1'b1);
    localparam logic [LEN_W-1:0]  ZERO_L  = {LEN_W{1'b0}};

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;
    logic [ADDR_W-1:0] pc_word_s;

    // A load length is usable only if it is non-zero and fits the memory.
    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != ZERO_L) && ({1'b0, len} <= DEPTH_L);
    endfunction

    assign pc_word_s = {2'b00, bus.cpu_pc[ADDR_W-1:2]};

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_WAIT;
            len_q        <= ZERO_L;
            word_cnt_q   <= ZERO_L;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 32'h0000_0000;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    // Next-state logic: load acceptance, byte assembly and word sequencing.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        case (state_q)
            ST_WAIT, ST_RUN: begin
                if (bus.load_start) begin
                    if (len_legal(bus.load_len)) begin
                        load_done_d  = 1'b0;
                        load_error_d = 1'b0;
                        len_d        = bus.load_len;
                        word_cnt_d   = ZERO_L;
                        byte_cnt_d   = 2'd0;
                        state_d      = ST_LOAD;
                    end else begin
                        // Illegal length: flag it and fall back to waiting.
                        load_error_d = 1'b1;
                        state_d      = ST_WAIT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (bus.byte_valid) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WRITE: begin
                // Counter never runs past the latched length.
                if (word_cnt_q < len_q) begin
                    word_cnt_d = word_cnt_q + ONE_L;
                end else begin
                    word_cnt_d = word_cnt_q;
                end
                if ((word_cnt_q + ONE_L) >= len_q) begin
                    load_done_d = 1'b1;
                    state_d     = ST_RELEASE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Moore output decode; only mem_addr and fetch_fault follow cpu_pc in RUN.
    always_comb begin
        bus.cpu_stall    = 1'b1;
        bus.byte_ready   = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_wdata    = 32'h0000_0000;
        bus.cpu_pc_reset = 1'b0;
        bus.mem_addr     = ADDR_W'(word_cnt_q);
        bus.fetch_fault  = 1'b0;
        bus.load_done    = load_done_q;
        bus.load_error   = load_error_q;
        case (state_q)
            ST_LOAD: begin
                bus.byte_ready = 1'b1;
            end
            ST_WRITE: begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = asm_q;
            end
            ST_RELEASE: begin
                bus.cpu_pc_reset = 1'b1;
            end
            ST_RUN: begin
                bus.cpu_stall   = 1'b0;
                bus.mem_addr    = pc_word_s;
                bus.fetch_fault = (bus.cpu_pc[1:0] != 2'b00) || (pc_word_s >= DEPTH_A);
            end
            default: begin
                bus.cpu_stall = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed/randomized bench for imem_boot_ctrl. Expected memory contents are
// derived from the byte stream by little-endian packing; fetch mapping is
// derived from byte-address arithmetic.
module tb_imem_boot_ctrl;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int LEN_W  = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    imem_boot_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    imem_boot_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/pulse monitor, sampled on the falling edge.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          we_ready_cnt = 0;
    int          we_run_cnt = 0;
    int          pcr_cnt = 0;
    int          pcr_cyc = 0;
    int          stall_fall_cyc = 0;
    logic        prev_we = 1'b0;
    logic        prev_stall = 1'b1;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            wr_cyc_q.push_back(cyc);
            if (bus.byte_ready) we_ready_cnt <= we_ready_cnt + 1;
            if (prev_we) we_run_cnt <= we_run_cnt + 1;
        end
        if (bus.cpu_pc_reset) begin
            pcr_cnt <= pcr_cnt + 1;
            pcr_cyc <= cyc;
        end
        if (prev_stall && !bus.cpu_stall) stall_fall_cyc <= cyc;
        prev_we    <= bus.mem_we;
        prev_stall <= bus.cpu_stall;
    end

    int acc_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input int len);
        bus.load_start = 1'b1;
        bus.load_len   = LEN_W'(len);
        @(posedge clk); #1;
        bus.load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
        bit ok = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.byte_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                acc_q.push_back(cyc);
                break;
            end
        end
        bus.byte_valid = 1'b0;
        if (!ok) check({tag, "_byte_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_run(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!bus.cpu_stall) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_reach_run"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pack_word(input logic [7:0] b[$], input int i);
        return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
    endfunction

    // Full program load plus checks of every write, the release pulse and timing.
    task automatic run_load(input logic [7:0] prog[$], input int gap_max, input string tag);
        int nwords = prog.size() / 4;
        int base   = wr_addr_q.size();
        int pcr0   = pcr_cnt;
        int wer0   = we_ready_cnt;
        int wrun0  = we_run_cnt;
        acc_q.delete();
        start_load(nwords);
        check({tag, "_stall_in_load"}, 32'(bus.cpu_stall), 32'd1);
        check({tag, "_done_cleared"}, 32'(bus.load_done), 32'd0);
        foreach (prog[i]) send_byte(prog[i], (gap_max == 0) ? 0 : $urandom_range(gap_max, 0), tag);
        wait_run(tag);
        check({tag, "_nwrites"}, 32'(wr_addr_q.size() - base), 32'(nwords));
        for (int i = 0; i < nwords && (base + i) < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[base+i], 32'(i));
            check($sformatf("%s_data%0d", tag, i), wr_data_q[base+i], pack_word(prog, i));
            if (acc_q.size() > 4*i+3)
                check($sformatf("%s_lat%0d", tag, i), 32'(wr_cyc_q[base+i]), 32'(acc_q[4*i+3]));
        end
        check({tag, "_pcr_pulses"}, 32'(pcr_cnt - pcr0), 32'd1);
        check({tag, "_we_ready_overlap"}, 32'(we_ready_cnt - wer0), 32'd0);
        check({tag, "_we_multi_cycle"}, 32'(we_run_cnt - wrun0), 32'd0);
        check({tag, "_load_done"}, 32'(bus.load_done), 32'd1);
        check({tag, "_stall_fall"}, 32'(stall_fall_cyc - pcr_cyc), 32'd1);
    endtask

    initial begin
        logic [7:0] prog1[$];
        logic [7:0] prog_r[$];
        int base;
        logic [31:0] pc;

        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.cpu_pc     = 32'h0;
        prog1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00};

        // Reset state
        #12;
        check("rst_stall", 32'(bus.cpu_stall), 32'd1);
        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_pcr", 32'(bus.cpu_pc_reset), 32'd0);
        check("rst_done", 32'(bus.load_done), 32'd0);
        check("rst_err", 32'(bus.load_error), 32'd0);
        check("rst_fault", 32'(bus.fetch_fault), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // 1: two-word program, back-to-back bytes
        run_load(prog1, 0, "s1");

        // 2: illegal lengths, then a legal load clears the error
        base = wr_addr_q.size();
        start_load(0);
        check("s2_err_len0", 32'(bus.load_error), 32'd1);
        check("s2_stall_len0", 32'(bus.cpu_stall), 32'd1);
        start_load(DEPTH + 1);
        check("s2_err_len65", 32'(bus.load_error), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("s2_stall_held", 32'(bus.cpu_stall), 32'd1);
        check("s2_no_writes", 32'(wr_addr_q.size() - base), 32'd0);
        start_load(1);
        check("s2_err_cleared", 32'(bus.load_error), 32'd0);
        prog_r.delete();
        for (int i = 0; i < 4; i++) prog_r.push_back(8'($urandom));
        foreach (prog_r[i]) send_byte(prog_r[i], 0, "s2");
        wait_run("s2");
        check("s2_data", wr_data_q[wr_data_q.size()-1], pack_word(prog_r, 0));

        // 3: same program with random gaps
        run_load(prog1, 3, "s3");

        // 4: fetch mapping in RUN
        base = wr_addr_q.size();
        bus.cpu_pc = 32'h14; #1;
        check("s4_addr_14", bus.mem_addr, 32'd5);
        check("s4_fault_14", 32'(bus.fetch_fault), 32'd0);
        bus.cpu_pc = 32'h06; #1;
        check("s4_fault_06", 32'(bus.fetch_fault), 32'd1);
        bus.cpu_pc = 32'h100; #1;
        check("s4_addr_100", bus.mem_addr, 32'd64);
        check("s4_fault_100", 32'(bus.fetch_fault), 32'd1);
        for (int i = 0; i < 6; i++) begin
            pc = (i % 2 == 0) ? 32'($urandom_range(300, 0)) : $urandom;
            bus.cpu_pc = pc; #1;
            check("s4_rand_addr", bus.mem_addr, pc / 4);
            check("s4_rand_fault", 32'(bus.fetch_fault),
                  32'(((pc % 4) != 0) || ((pc / 4) >= DEPTH)));
        end
        @(posedge clk); #1;
        check("s4_no_writes", 32'(wr_addr_q.size() - base), 32'd0);
        bus.cpu_pc = 32'h0;

        // 5: asynchronous reset mid-word, then a clean reload
        start_load(1);
        send_byte(8'hAA, 0, "s5");
        send_byte(8'hBB, 0, "s5");
        #2 reset = 1'b0;
        #1;
        check("s5_rst_stall", 32'(bus.cpu_stall), 32'd1);
        check("s5_rst_ready", 32'(bus.byte_ready), 32'd0);
        check("s5_rst_we", 32'(bus.mem_we), 32'd0);
        check("s5_rst_addr", bus.mem_addr, 32'd0);
        check("s5_rst_done", 32'(bus.load_done), 32'd0);
        check("s5_rst_err", 32'(bus.load_error), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        prog_r = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(prog_r, 0, "s5");

        // 6: reload a single random word from RUN
        prog_r.delete();
        for (int i = 0; i < 4; i++) prog_r.push_back(8'($urandom));
        run_load(prog_r, 2, "s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
